// File: rtl/branch_resolve_unit.sv
// Execute-stage resolver for conditional branches, JAL and JALR with a held redirect handshake to fetch.
// Optional misaligned-target trap is enabled by defining BRANCH_MISALIGN_TRAP_EN.
module branch_resolve_unit #(
    parameter int XLEN           = 32,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic            req_pred_taken,
    input  logic [XLEN-1:0] req_pred_pc,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            trap_valid
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        REDIRECT
    } state_t;

    localparam logic [1:0] KindBranch = 2'd0;
    localparam logic [1:0] KindJal    = 2'd1;
    localparam logic [1:0] KindJalr   = 2'd2;

`ifdef BRANCH_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [1:0]        kind_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, pc_q, imm_q, predPc_q;
    logic              predTaken_q;
    logic [XLEN-1:0]   redirPc_q, redirPc_d;

    logic              baseCond, cond, taken, misaligned, mispredict, isJump;
    logic [XLEN-1:0]   sum, target, linkPc, nextPc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            predTaken_q <= 1'b0;
            predPc_q    <= '0;
            redirPc_q   <= '0;
        end else begin
            state_q   <= state_d;
            redirPc_q <= redirPc_d;
            if (state_q == IDLE && req_valid) begin
                kind_q      <= req_kind;
                op_q        <= req_op;
                a_q         <= req_a;
                b_q         <= req_b;
                pc_q        <= req_pc;
                imm_q       <= req_imm;
                predTaken_q <= req_pred_taken;
                predPc_q    <= req_pred_pc;
            end
        end
    end

    // op_q = {mode, un, neg}: mode picks eq vs lt, un picks unsigned lt, neg inverts.
    always_comb begin
        if (!op_q[2]) begin
            baseCond = (a_q == b_q);
        end else if (op_q[1]) begin
            baseCond = (a_q < b_q);
        end else begin
            baseCond = ($signed(a_q) < $signed(b_q));
        end
        cond = baseCond ^ op_q[0];

        isJump = (kind_q == KindJal) || (kind_q == KindJalr);
        if (kind_q == KindBranch) begin
            taken = cond;
        end else begin
            taken = isJump;
        end

        sum    = (kind_q == KindJalr) ? (a_q + imm_q) : (pc_q + imm_q);
        target = (kind_q == KindJalr) ? {sum[XLEN-1:1], 1'b0} : sum;
        linkPc = pc_q + XLEN'(4);
        nextPc = taken ? target : linkPc;

        misaligned = TrapEn && taken && ((target % XLEN'(RESET_PC_ALIGN)) != '0);
        mispredict = !misaligned &&
                     ((taken != predTaken_q) || (taken && (predPc_q != target)));
    end

    always_comb begin
        state_d        = state_q;
        redirPc_d      = redirPc_q;
        req_ready      = 1'b0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        res_mispredict = 1'b0;
        link_valid     = 1'b0;
        link_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b0;
        trap_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                res_valid      = 1'b1;
                res_taken      = taken;
                res_mispredict = mispredict;
                link_valid     = isJump && !misaligned;
                link_data      = linkPc;
                trap_valid     = misaligned;
                if (mispredict) begin
                    state_d   = REDIRECT;
                    redirPc_d = nextPc;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = redirPc_q;
                if (redirect_ready) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus randomized requests against a reference model.
module tb_branch_resolve_unit;

`ifdef BRANCH_MISALIGN_TRAP_EN
    localparam int ALIGN = 4;
`else
    localparam int ALIGN = 2;
`endif

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, req_pc, req_imm, req_pred_pc;
    logic        req_pred_taken;
    logic        res_valid, res_taken, res_mispredict, link_valid;
    logic [31:0] link_data, redirect_pc;
    logic        redirect_valid, redirect_ready, flush, trap_valid;

    typedef struct {
        logic        taken;
        logic        mis;
        logic        linkValid;
        logic        trap;
        logic [31:0] linkData;
        logic [31:0] redirPc;
    } exp_t;

    exp_t        resQ[$];
    logic [31:0] redirQ[$];

    int total = 0;
    int bad   = 0;
    int flushCount = 0;
    bit readyMode  = 1'b1;
    bit forcedReady = 1'b0;

    branch_resolve_unit #(.XLEN(32), .RESET_PC_ALIGN(ALIGN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_imm(req_imm),
        .req_pred_taken(req_pred_taken), .req_pred_pc(req_pred_pc),
        .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
        .link_valid(link_valid), .link_data(link_data),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .trap_valid(trap_valid)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] refTarget(input logic [1:0] kind, input logic [31:0] a,
                                              input logic [31:0] pc, input logic [31:0] imm);
        if (kind == 2'd2) return (a + imm) & 32'hFFFF_FFFE;
        return pc + imm;
    endfunction

    function automatic logic refTaken(input logic [1:0] kind, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        logic c;
        case (op)
            3'b000, 3'b010: c = (a == b);
            3'b001, 3'b011: c = (a != b);
            3'b100:         c = ($signed(a) <  $signed(b));
            3'b101:         c = ($signed(a) >= $signed(b));
            3'b110:         c = (a <  b);
            default:        c = (a >= b);
        endcase
        if (kind == 2'd0) return c;
        if (kind == 2'd3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t refModel(input logic [1:0] kind, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      input logic pt, input logic [31:0] ppc);
        exp_t e;
        logic [31:0] tgt;
        tgt = refTarget(kind, a, pc, imm);
        e.taken = refTaken(kind, op, a, b);
        e.trap  = 1'b0;
`ifdef BRANCH_MISALIGN_TRAP_EN
        e.trap  = e.taken && ((tgt % ALIGN) != 0);
`endif
        e.mis       = !e.trap && ((e.taken != pt) || (e.taken && ppc != tgt));
        e.linkValid = (kind == 2'd1 || kind == 2'd2) && !e.trap;
        e.linkData  = pc + 32'd4;
        e.redirPc   = e.taken ? tgt : pc + 32'd4;
        return e;
    endfunction

    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic pt, input logic [31:0] ppc);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("reqReadyTimeout", 32'(req_ready), 32'd1);
            return;
        end
        req_kind = kind; req_op = op; req_a = a; req_b = b;
        req_pc = pc; req_imm = imm; req_pred_taken = pt; req_pred_pc = ppc;
        req_valid = 1'b1;
        resQ.push_back(refModel(kind, op, a, b, pc, imm, pt, ppc));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Sole driver of redirect_ready: random or forced, updated just after each rising edge.
    initial begin
        redirect_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2 redirect_ready = readyMode ? forcedReady : ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: pops expected results on res_valid and expected redirects on the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (res_valid) begin
                    if (resQ.size() == 0) begin
                        checkOutput("unexpectedResult", 32'd1, 32'd0);
                    end else begin
                        e = resQ.pop_front();
                        checkOutput("resTaken", 32'(res_taken), 32'(e.taken));
                        checkOutput("resMispredict", 32'(res_mispredict), 32'(e.mis));
                        checkOutput("trapValid", 32'(trap_valid), 32'(e.trap));
                        checkOutput("linkValid", 32'(link_valid), 32'(e.linkValid));
                        if (e.linkValid) checkOutput("linkData", link_data, e.linkData);
                        if (e.mis) redirQ.push_back(e.redirPc);
                    end
                end
                if (redirect_valid) begin
                    if (redirQ.size() == 0) begin
                        checkOutput("unexpectedRedirect", 32'd1, 32'd0);
                    end else begin
                        checkOutput("redirectPc", redirect_pc, redirQ[0]);
                        if (redirect_ready) begin
                            checkOutput("flushOnHandshake", 32'(flush), 32'd1);
                            void'(redirQ.pop_front());
                            flushCount++;
                        end
                    end
                end else begin
                    checkOutput("flushIdle", 32'(flush), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [1:0]  k;
        logic [2:0]  op;
        logic [31:0] a, b, pc, imm, tgt, ppc, r;
        logic        pt;
        int          fc0, waited;

        rst_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_op = '0;
        req_a = '0; req_b = '0; req_pc = '0; req_imm = '0;
        req_pred_taken = 1'b0; req_pred_pc = '0;

        repeat (2) @(negedge clk);
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetResValid", 32'(res_valid), 32'd0);
        checkOutput("resetRedirect", 32'(redirect_valid), 32'd0);
        checkOutput("resetLinkValid", 32'(link_valid), 32'd0);
        checkOutput("resetTrap", 32'(trap_valid), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // beq taken but predicted not-taken; redirect held while ready stays low.
        forcedReady = 1'b0;
        applyStimulus(2'd0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("redirectHeld", 32'(redirect_valid), 32'd1);
            checkOutput("redirectHeldPc", redirect_pc, 32'h120);
        end
        fc0 = flushCount;
        forcedReady = 1'b1;
        @(negedge clk);
        forcedReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("singleFlush", 32'(flushCount), 32'(fc0 + 1));
        checkOutput("redirectDropped", 32'(redirect_valid), 32'd0);

        // blt signed taken, bltu not taken, both correctly predicted.
        applyStimulus(2'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340);
        @(negedge clk);
        checkOutput("evalReqReady", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("bltReqReadyBack", 32'(req_ready), 32'd1);
        applyStimulus(2'd0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("bltuReqReadyBack", 32'(req_ready), 32'd1);

        // JALR clears bit 0, then JAL wrapping past 2^32, then an offset misaligned to 4 bytes.
        forcedReady = 1'b1;
        applyStimulus(2'd2, 3'b000, 32'h1001, 32'd0, 32'h200, 32'h4, 1'b1, 32'h1004);
        applyStimulus(2'd1, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h0);
        applyStimulus(2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h6, 1'b0, 32'h0);
        applyStimulus(2'd3, 3'b000, 32'd7, 32'd7, 32'h400, 32'h10, 1'b0, 32'h0);

        // Reset while a redirect is pending must discard it.
        forcedReady = 1'b0;
        applyStimulus(2'd0, 3'b001, 32'd1, 32'd2, 32'h500, 32'h80, 1'b0, 32'h0);
        waited = 0;
        @(negedge clk);
        while (!redirect_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("redirectBeforeReset", 32'(redirect_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        resQ.delete();
        redirQ.delete();
        #1;
        checkOutput("asyncResetRedirect", 32'(redirect_valid), 32'd0);
        checkOutput("asyncResetFlush", 32'(flush), 32'd0);
        checkOutput("asyncResetReqReady", 32'(req_ready), 32'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noStaleRedirect", 32'(redirect_valid), 32'd0);
            checkOutput("postResetReqReady", 32'(req_ready), 32'd1);
        end

        // Randomized traffic with random fetch readiness.
        readyMode = 1'b0;
        for (int n = 0; n < 300; n++) begin
            k  = 2'($urandom_range(0, 3));
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)));
            pc = $urandom & 32'hFFFF_FFFE;
            r  = $urandom;
            imm = {{20{r[11]}}, r[11:0]};
            tgt = refTarget(k, a, pc, imm);
            pt  = 1'($urandom_range(0, 1));
            ppc = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
            applyStimulus(k, op, a, b, pc, imm, pt, ppc);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end

        readyMode = 1'b1;
        forcedReady = 1'b1;
        waited = 0;
        while ((resQ.size() != 0 || redirQ.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput("resQueueDrained", 32'(resQ.size()), 32'd0);
        checkOutput("redirQueueDrained", 32'(redirQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
